// File: rtl/sobel_edge_3x3.sv
// Sobel gradient stage: 3x3 window in, saturated 8-bit magnitude and edge flag out.
// Three-stage pipeline; raster counters blank windows touching the frame's top/left border.
module sobel_edge_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iValid,
    input  logic [7:0] iData_11,
    input  logic [7:0] iData_12,
    input  logic [7:0] iData_13,
    input  logic [7:0] iData_21,
    input  logic [7:0] iData_22,
    input  logic [7:0] iData_23,
    input  logic [7:0] iData_31,
    input  logic [7:0] iData_32,
    input  logic [7:0] iData_33,
    input  logic [7:0] iThreshold,
    output logic       oValid,
    output logic [7:0] oMag,
    output logic       oEdge
);

    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
        logic signed [10:0] d;
        d = $signed({1'b0, p}) - $signed({1'b0, n});
        if (d < 0)
            d = -d;
        return d[9:0];
    endfunction

    function automatic logic [7:0] sat8(input logic [10:0] s);
        return (s > 11'd255) ? 8'hFF : s[7:0];
    endfunction

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               w_border_p0;
    logic [2:0]         r_vld;
    logic [9:0]         r_gxp_p1, r_gxn_p1, r_gyp_p1, r_gyn_p1;
    logic               r_border_p1;
    logic [9:0]         r_gx_p2, r_gy_p2;
    logic               r_border_p2;
    logic [10:0]        w_sum_p2;
    logic [7:0]         w_mag_p2;

    // Counters hold the position of the beat currently on the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (iValid) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign w_border_p0 = (r_col < CW'(2)) || (r_row < RW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vld <= '0;
        else
            r_vld <= {r_vld[1:0], iValid};
    end

    assign oValid = r_vld[2];

    // Stage 1: weighted column/row sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gxp_p1    <= '0;
            r_gxn_p1    <= '0;
            r_gyp_p1    <= '0;
            r_gyn_p1    <= '0;
            r_border_p1 <= 1'b0;
        end else if (iValid) begin
            r_gxp_p1    <= wsum(iData_13, iData_23, iData_33);
            r_gxn_p1    <= wsum(iData_11, iData_21, iData_31);
            r_gyp_p1    <= wsum(iData_31, iData_32, iData_33);
            r_gyn_p1    <= wsum(iData_11, iData_12, iData_13);
            r_border_p1 <= w_border_p0;
        end
    end

    // Stage 2: absolute gradients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gx_p2     <= '0;
            r_gy_p2     <= '0;
            r_border_p2 <= 1'b0;
        end else if (r_vld[0]) begin
            r_gx_p2     <= absdiff(r_gxp_p1, r_gxn_p1);
            r_gy_p2     <= absdiff(r_gyp_p1, r_gyn_p1);
            r_border_p2 <= r_border_p1;
        end
    end

    // Stage 3: magnitude, saturation, blanking and threshold
    assign w_sum_p2 = {1'b0, r_gx_p2} + {1'b0, r_gy_p2};
    assign w_mag_p2 = r_border_p2 ? 8'd0 : sat8(w_sum_p2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oMag  <= '0;
            oEdge <= 1'b0;
        end else if (r_vld[1]) begin
            oMag  <= w_mag_p2;
            oEdge <= !r_border_p2 && (w_mag_p2 > iThreshold);
        end
    end

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Scoreboard bench for sobel_edge_3x3 on an 8x6 frame with directed windows.
module tb_sobel_edge_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            iValid = 1'b0;
    logic [8:0][7:0] win = '0;
    logic [7:0]      thr = 8'd0;
    logic            oValid;
    logic [7:0]      oMag;
    logic            oEdge;

    sobel_edge_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid),
        .iData_11(win[0]), .iData_12(win[1]), .iData_13(win[2]),
        .iData_21(win[3]), .iData_22(win[4]), .iData_23(win[5]),
        .iData_31(win[6]), .iData_32(win[7]), .iData_33(win[8]),
        .iThreshold(thr), .oValid(oValid), .oMag(oMag), .oEdge(oEdge)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int mag; int edg; int stamp; } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n_seen = 0;
    int pos_c = 0;
    int pos_r = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every output beat must match the oldest pending expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && oValid) begin
            n_seen++;
            if (q.size() == 0) begin
                chk("unexpected_oValid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("mag", oMag, e.mag);
                chk("edge", oEdge, e.edg);
                chk("latency", cyc - e.stamp, 3);
            end
        end
    end

    task automatic drive(input logic [8:0][7:0] w, input int mag_int);
        int st;
        bit b;
        exp_t x;
        @(negedge clk);
        win = w;
        iValid = 1'b1;
        st = cyc;
        @(posedge clk);
        b = (pos_c < 2) || (pos_r < 2);
        x.mag = b ? 0 : mag_int;
        x.edg = (!b && (mag_int > int'(thr))) ? 1 : 0;
        x.stamp = st;
        q.push_back(x);
        if (pos_c == W - 1) begin
            pos_c = 0;
            pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
        end else begin
            pos_c = pos_c + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iValid = 1'b0;
            @(posedge clk);
        end
    endtask

    logic [8:0][7:0] w_uni, w_step, w_small;
    int base;

    initial begin
        for (int i = 0; i < 9; i++) begin
            w_uni[i]   = 8'd100;
            w_small[i] = 8'd0;
        end
        w_small[8] = 8'd40;
        for (int r = 0; r < 3; r++) begin
            w_step[r*3+0] = 8'd0;
            w_step[r*3+1] = 8'd128;
            w_step[r*3+2] = 8'd255;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_oValid", oValid, 0);
        chk("reset_oMag", oMag, 0);
        chk("reset_oEdge", oEdge, 0);
        rst_n = 1'b1;

        thr = 8'd128;
        base = n_seen;
        for (int i = 0; i < W * H; i++) drive(w_uni, 0);
        idle(5);
        chk("uniform_pulses", n_seen - base, W * H);

        // Two frames of vertical steps: border pattern must repeat after wrap.
        for (int i = 0; i < 2 * W * H; i++) drive(w_step, 255);
        idle(5);

        thr = 8'd80;
        for (int i = 0; i < W * H; i++) drive(w_small, 80);
        idle(5);
        thr = 8'd79;
        for (int i = 0; i < W * H; i++) drive(w_small, 80);
        idle(5);

        base = n_seen;
        drive(w_step, 255);
        idle(1);
        drive(w_step, 255);
        drive(w_step, 255);
        idle(1);
        idle(4);
        chk("bubble_pulses", n_seen - base, 3);

        // Move into the interior so a missed counter reset would show as 255.
        while (!(pos_r == 2 && pos_c == 2)) drive(w_step, 255);
        drive(w_step, 255);
        drive(w_step, 255);
        @(negedge clk);
        #2;
        iValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_oValid", oValid, 0);
        chk("midreset_oMag", oMag, 0);
        chk("midreset_oEdge", oEdge, 0);
        q.delete();
        pos_c = 0;
        pos_r = 0;
        base = n_seen;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(6);
        chk("stale_pulses", n_seen - base, 0);
        drive(w_step, 255);
        idle(5);
        chk("post_reset_pulses", n_seen - base, 1);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
